// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Operand and result valid/ready handshakes for div_iter.
interface div_iter_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nx,
  output logic [WIDTH-1:0] q_nx
);

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] t;

  // r[WIDTH] is always 0 between steps, so widening by one bit leaves the
  // trial difference and its sign identical to the WIDTH+1-bit form.
  always_comb begin
    r_sh = {r, q[WIDTH-1]};
    t    = r_sh - {2'b00, d};
    if (!t[WIDTH+1]) begin
      r_nx = t[WIDTH:0];
      q_nx = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nx = r_sh[WIDTH:0];
      q_nx = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on operands and results.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  div_iter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state;
  div_state_e       state_nx;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH:0]   r_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;
  logic             accept;
  logic             finish;
  logic             release_res;
  logic             zero_div;
  logic             last_step;

  assign zero_div  = (bus.divisor == '0);
  assign last_step = (cnt == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r    (r_r),
    .q    (q_r),
    .d    (d_r),
    .r_nx (r_nx),
    .q_nx (q_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    finish      = 1'b0;
    release_res = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          release_res = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
      d_r <= '0;
      r_r <= '0;
      cnt <= '0;
    end else if (accept) begin
      q_r <= bus.dividend;
      d_r <= bus.divisor;
      r_r <= '0;
      cnt <= CNT_W'(WIDTH - 1);
    end else if (state == CALC) begin
      q_r <= q_nx;
      r_r <= r_nx;
      cnt <= cnt - 1'b1;
    end
  end

  // Result registers are loaded only on entry to DONE, so nothing partial is
  // ever visible on the result port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
    end else if (accept && zero_div) begin
      quot_r <= '1;
      rem_r  <= bus.dividend;
      dbz_r  <= 1'b1;
    end else if (finish) begin
      quot_r <= q_nx;
      rem_r  <= r_nx[WIDTH-1:0];
      dbz_r  <= 1'b0;
    end else if (release_res) begin
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule
